io_pwr_seq_ctrl: RTL



---
 rtl/io_pwr_seq_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/io_pwr_seq_ctrl.sv
// Power sequencer for the GF22FDX EG 1.8V IO ring: isolation, retention and OE permit.
// Optional supply-wait timeout enabled by defining IO_PWR_SEQ_TIMEOUT_EN.
module io_pwr_seq_ctrl #(
   parameter int unsigned DEB_CYC     = 16,
   parameter int unsigned SETTLE_CYC  = 32,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned TIMEOUT_CYC = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vddio_ok_i,
   input  logic       vdd_ok_i,
   input  logic       pwr_req_i,
   input  logic       ret_req_i,
   output logic       pad_iso_o,
   output logic       pad_ret_o,
   output logic       pad_oe_en_o,
   output logic       io_ready_o,
   output logic       fault_o,
   output logic [2:0] state_o
);

   localparam logic [2:0] S_OFF    = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_DEB    = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_ACTIVE = 3'd4;
   localparam logic [2:0] S_RETAIN = 3'd5;
   localparam logic [2:0] S_FAULT  = 3'd6;

   localparam longint unsigned CNT_CAP = (64'd1 << CNT_W) - 64'd1;
   localparam longint unsigned NEED_DS = (DEB_CYC > SETTLE_CYC) ? 64'(DEB_CYC) : 64'(SETTLE_CYC);
`ifdef IO_PWR_SEQ_TIMEOUT_EN
   localparam longint unsigned NEED = (64'(TIMEOUT_CYC) > NEED_DS) ? 64'(TIMEOUT_CYC) : NEED_DS;
`else
   localparam longint unsigned NEED = NEED_DS;
`endif

   generate
      if (NEED > CNT_CAP || DEB_CYC < 2 || SETTLE_CYC < 1) begin : g_param_chk
         $error("io_pwr_seq_ctrl: CNT_W too narrow or cycle parameters out of range");
      end
   endgenerate

   logic             vio_s1_q, vio_q, vcore_s1_q, vcore_q;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             iso_q, ret_q, oe_q, rdy_q, fault_q;
   logic             iso_d, ret_d, oe_d, rdy_d, fault_d;
   logic             both_ok, timeout_hit;

   assign both_ok = vio_q & vcore_q;
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef IO_PWR_SEQ_TIMEOUT_EN
   assign timeout_hit = !both_ok && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_OFF: begin
            cnt_d = '0;
            if (pwr_req_i) state_d = S_WAIT;
         end
         S_WAIT: begin
`ifdef IO_PWR_SEQ_TIMEOUT_EN
            cnt_d = cnt_inc;
`else
            cnt_d = '0;
`endif
            if (timeout_hit) state_d = S_FAULT;
            else if (!pwr_req_i) state_d = S_OFF;
            else if (both_ok) begin
               state_d = S_DEB;
               cnt_d   = '0;
            end
         end
         S_DEB: begin
            // A supply drop here is a glitch, not a fault: restart the wait.
            if (!both_ok) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else if (!pwr_req_i) state_d = S_OFF;
            else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end else cnt_d = cnt_inc;
         end
         S_SETTLE: begin
            cnt_d = cnt_inc;
            if (!both_ok) state_d = S_FAULT;
            else if (!pwr_req_i) state_d = S_OFF;
            else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (!both_ok) state_d = S_FAULT;
            else if (!pwr_req_i) state_d = S_OFF;
            else if (ret_req_i) state_d = S_RETAIN;
         end
         S_RETAIN: begin
            // Core may power down while retained; only VDDIO loss is fatal.
            if (!vio_q) state_d = S_FAULT;
            else if (!pwr_req_i) state_d = S_OFF;
            else if (!ret_req_i && vcore_q) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end
         end
         S_FAULT: begin
            if (!pwr_req_i) state_d = S_OFF;
         end
         default: state_d = S_OFF;
      endcase
   end

   always_comb begin
      iso_d   = 1'b1;
      ret_d   = 1'b0;
      oe_d    = 1'b0;
      rdy_d   = 1'b0;
      fault_d = 1'b0;
      case (state_d)
         S_SETTLE: iso_d = 1'b0;
         S_ACTIVE: begin
            iso_d = 1'b0;
            oe_d  = 1'b1;
            rdy_d = 1'b1;
         end
         S_RETAIN: ret_d   = 1'b1;
         S_FAULT:  fault_d = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vio_s1_q   <= 1'b0;
         vio_q      <= 1'b0;
         vcore_s1_q <= 1'b0;
         vcore_q    <= 1'b0;
         state_q    <= S_OFF;
         cnt_q      <= '0;
         iso_q      <= 1'b1;
         ret_q      <= 1'b0;
         oe_q       <= 1'b0;
         rdy_q      <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         vio_s1_q   <= vddio_ok_i;
         vio_q      <= vio_s1_q;
         vcore_s1_q <= vdd_ok_i;
         vcore_q    <= vcore_s1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         iso_q      <= iso_d;
         ret_q      <= ret_d;
         oe_q       <= oe_d;
         rdy_q      <= rdy_d;
         fault_q    <= fault_d;
      end
   end

   assign pad_iso_o   = iso_q;
   assign pad_ret_o   = ret_q;
   assign pad_oe_en_o = oe_q;
   assign io_ready_o  = rdy_q;
   assign fault_o     = fault_q;
   assign state_o     = state_q;

endmodule
